alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//  Command front end for the 4-bit combinational ALU. Buffers (A,B,opcode) commands
//  from a valid/ready producer in a small FIFO and drives the FIFO head onto the ALU
//  inputs. Registers the ALU result into an output stage with its own valid/ready
//  handshake. Sits directly upstream of the ALU and also captures its output.
// PARAMETERS
//  DEPTH   4  command FIFO entries; power of 2, >=2
//  DATA_W  4  operand/result width; must match the ALU
//  OP_W    2  opcode width; 00=ADD 01=SUB 10=AND 11=OR
// PORTS
//  clk         in   1                    single clock, rising edge
//  rst         in   1                    synchronous, active-high reset
//  in_valid    in   1                    producer command valid
//  in_ready    out  1                    FIFO can accept a command
//  in_a        in   DATA_W               operand A
//  in_b        in   DATA_W               operand B
//  in_op       in   OP_W                 opcode
//  alu_a       out  DATA_W               to ALU A
//  alu_b       out  DATA_W               to ALU B
//  alu_op      out  OP_W                 to ALU opcode
//  alu_result  in   DATA_W               from ALU result (combinational)
//  out_valid   out  1                    registered result valid
//  out_ready   in   1                    consumer accepts result
//  out_result  out  DATA_W               registered result
//  out_op      out  OP_W                 opcode that produced out_result
//  count       out  $clog2(DEPTH+1)      FIFO occupancy
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge):
//    - FIFO pointers=0, count=0, FSM=IDLE.
//    - out_valid=0, out_result=0, out_op=0. in_ready=1 on the first cycle after reset.
//    - Commands still queued at reset are discarded; a result in the output register is dropped.
//  - Push: in_valid & in_ready at posedge writes the entry at wr_ptr. Pointers wrap modulo DEPTH.
//  - in_ready = (count != DEPTH). It depends only on count, so there is no bypass when full.
//  - Head drive:
//    - alu_a/alu_b/alu_op show the FIFO head combinationally when count>0; all zero when empty.
//    - There is no bypass when empty: a command pushed at edge k appears on alu_* after edge k.
//  - FSM:
//    - IDLE (out_valid=0):
//      - count>0 -> capture alu_result into out_result and head op into out_op, pop, go to VALID.
//    - VALID (out_valid=1):
//      - out_ready=0 -> hold; out_result and out_op stay stable.
//      - out_ready=1 & count>0 -> capture and pop next; stay VALID (back-to-back, 1 result/cycle).
//      - out_ready=1 & count=0 -> go to IDLE.
//  - Latency: command accepted at edge k into an empty FIFO with FSM=IDLE -> out_valid=1 after edge k+1.
//  - Simultaneous push+pop: count unchanged. Push into full while popping is still refused,
//    because in_ready was 0.
//  - Capacity: DEPTH queued plus 1 in the output register, so DEPTH+1 commands are accepted
//    while out_ready=0.
//  - Result is taken unmodified from the ALU; DATA_W wrap-around belongs to the ALU
//    (e.g. 2-3 -> 4'hF).
// CONFIGURATION
//  ALU_ZERO_FLAG_EN defined:
//    - Adds output out_zero (1 bit).
//    - Registered with out_result; equals (captured result == 0).
//    - Reset value 0; holds while stalled.
//  ALU_ZERO_FLAG_EN undefined: the port is absent; all other behaviour is identical.
// TESTING (bench instantiates alu_cmd_issuer plus the ALU, alu_* <-> ALU)
//  1. out_ready=1; push A=3,B=5,op=00 at edge k -> out_valid=1 after k+1 with out_result=8, out_op=00.
//  2. Push 9-5 (01), then 2-3 (01), then 4'hC & 4'hA (10) back-to-back with out_ready=1
//     -> results 4, F, 8 on consecutive cycles.
//  3. out_ready=0; push 5 commands -> all 5 accepted, in_ready=0 and count=4 afterwards.
//     Then out_ready=1 -> 5 results drain in order, in_ready=1 after the first drain.
//  4. Full FIFO and out_ready=1 with in_valid=1 in the same cycle -> the push is refused
//     that cycle; count goes 4->3.
//  5. Assert rst with 3 commands queued and out_valid=1 -> next cycle out_valid=0, count=0,
//     alu_*=0, in_ready=1. The first command after reset is issued normally.
//  6. ALU_ZERO_FLAG_EN defined: push 5-5 (01) -> out_zero=1 with out_result=0.
//     Then push 1|0 (11) -> out_zero=0.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command FIFO in front of a combinational 4-bit ALU, with a registered valid/ready result stage.
// Optional feature: define ALU_ZERO_FLAG_EN to add the registered out_zero flag.
module alu_cmd_issuer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4,
    parameter int OP_W   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_a,
    input  logic [DATA_W-1:0]            in_b,
    input  logic [OP_W-1:0]              in_op,
    output logic [DATA_W-1:0]            alu_a,
    output logic [DATA_W-1:0]            alu_b,
    output logic [OP_W-1:0]              alu_op,
    input  logic [DATA_W-1:0]            alu_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_result,
    output logic [OP_W-1:0]              out_op,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic                         out_zero
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_mem_a  [DEPTH];
    logic [DATA_W-1:0]   r_mem_b  [DEPTH];
    logic [OP_W-1:0]     r_mem_op [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_out_result;
    logic [OP_W-1:0]     r_out_op;
    logic                w_push;
    logic                w_pop;
    logic                w_capture;
    logic                w_not_empty;

    assign w_not_empty = (r_count != '0);
    // Ready depends on occupancy only, so a full FIFO refuses a push even while popping.
    assign in_ready    = (r_count != CNT_W'(DEPTH));
    assign w_push      = in_valid & in_ready;
    assign w_pop       = w_capture;

    assign alu_a  = w_not_empty ? r_mem_a[r_rd_ptr]  : '0;
    assign alu_b  = w_not_empty ? r_mem_b[r_rd_ptr]  : '0;
    assign alu_op = w_not_empty ? r_mem_op[r_rd_ptr] : '0;

    // NOTE: the storage array has no reset; occupancy and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= in_a;
            r_mem_b[r_wr_ptr]  <= in_b;
            r_mem_op[r_wr_ptr] <= in_op;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_capture    = 1'b1;
                    w_next_state = S_VALID;
                end
            end
            S_VALID: begin
                if (out_ready) begin
                    if (w_not_empty) w_capture    = 1'b1;
                    else             w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_result <= '0;
            r_out_op     <= '0;
        end else if (w_capture) begin
            r_out_result <= alu_result;
            r_out_op     <= alu_op;
        end
    end

    assign out_valid  = (r_state == S_VALID);
    assign out_result = r_out_result;
    assign out_op     = r_out_op;
    assign count      = r_count;

`ifdef ALU_ZERO_FLAG_EN
    logic r_out_zero;

    always_ff @(posedge clk) begin
        if (rst)            r_out_zero <= 1'b0;
        else if (w_capture) r_out_zero <= (alu_result == '0);
    end

    assign out_zero = r_out_zero;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus random traffic against a
// queue-based transaction model; the ALU is modelled in the bench and wired to alu_*.
module tb_alu_cmd_issuer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 4;
    localparam int OP_W   = 2;
    localparam int CNT_W  = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [OP_W-1:0]   out_op;
    logic [CNT_W-1:0]  count;
`ifdef ALU_ZERO_FLAG_EN
    logic              out_zero;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cmd_t              m_fifo[$];
    bit                m_ov;
    logic [DATA_W-1:0] m_res;
    logic [OP_W-1:0]   m_op;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .count      (count)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    function automatic logic [DATA_W-1:0] alu_ref(input cmd_t c);
        int r;
        case (c.op)
            2'b00:   r = int'(c.a) + int'(c.b);
            2'b01:   r = int'(c.a) - int'(c.b);
            2'b10:   r = int'(c.a & c.b);
            default: r = int'(c.a | c.b);
        endcase
        return DATA_W'(r);
    endfunction

    // Stand-in for the downstream combinational ALU.
    always_comb begin
        cmd_t c;
        c = '{a: alu_a, b: alu_b, op: alu_op};
        alu_result = alu_ref(c);
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit   can_push;
        cmd_t c;
        if (rst) begin
            m_fifo.delete();
            m_ov  = 1'b0;
            m_res = '0;
            m_op  = '0;
            return;
        end
        can_push = (m_fifo.size() < DEPTH);
        if (m_fifo.size() > 0 && (!m_ov || out_ready)) begin
            c     = m_fifo.pop_front();
            m_res = alu_ref(c);
            m_op  = c.op;
            m_ov  = 1'b1;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        if (in_valid && can_push) m_fifo.push_back('{a: in_a, b: in_b, op: in_op});
    endtask

    task automatic compare_all();
        cmd_t h;
        h = (m_fifo.size() > 0) ? m_fifo[0] : '0;
        check("out_valid",  32'(out_valid),  32'(m_ov));
        check("out_result", 32'(out_result), 32'(m_res));
        check("out_op",     32'(out_op),     32'(m_op));
        check("count",      32'(count),      32'(m_fifo.size()));
        check("in_ready",   32'(in_ready),   32'(m_fifo.size() != DEPTH));
        check("alu_a",      32'(alu_a),      32'(h.a));
        check("alu_b",      32'(alu_b),      32'(h.b));
        check("alu_op",     32'(alu_op),     32'(h.op));
`ifdef ALU_ZERO_FLAG_EN
        check("out_zero",   32'(out_zero),   32'(m_res == '0));
`endif
    endtask

    task automatic step(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [OP_W-1:0] op, input logic rdy, input logic r);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = rdy;
        rst       = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        m_ov      = 1'b0;
        m_res     = '0;
        m_op      = '0;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count",    32'(count),    32'd0);

        // 1: single ADD, result one edge after acceptance
        step(1, 4'd3, 4'd5, 2'b00, 1, 0);
        check("t1_not_yet", 32'(out_valid), 32'd0);
        step(0, 0, 0, 0, 1, 0);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_res",   32'(out_result), 32'd8);

        // 2: back-to-back results 4, F, 8
        step(1, 4'd9, 4'd5, 2'b01, 1, 0);
        step(1, 4'd2, 4'd3, 2'b01, 1, 0);
        check("t2_r0", 32'(out_result), 32'h4);
        step(1, 4'hC, 4'hA, 2'b10, 1, 0);
        check("t2_r1", 32'(out_result), 32'hF);
        step(0, 0, 0, 0, 1, 0);
        check("t2_r2", 32'(out_result), 32'h8);
        step(0, 0, 0, 0, 1, 0);

        // 3: stalled consumer absorbs DEPTH+1 commands
        for (int i = 0; i < 5; i++) step(1, 4'(i + 1), 4'(i), 2'b00, 0, 0);
        check("t3_count", 32'(count),    32'd4);
        check("t3_ready", 32'(in_ready), 32'd0);

        // 4: push against a full FIFO while draining is refused
        step(1, 4'hE, 4'hE, 2'b11, 1, 0);
        check("t4_count", 32'(count),    32'd3);
        check("t4_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
        check("t3_drained", 32'(out_valid), 32'd0);

        // 5: reset with queued commands and a pending result
        for (int i = 0; i < 4; i++) step(1, 4'(i + 7), 4'd1, 2'b01, 0, 0);
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_count", 32'(count),     32'd3);
        step(0, 0, 0, 0, 0, 1);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_count", 32'(count),     32'd0);
        check("t5_alu_a", 32'(alu_a),     32'd0);
        check("t5_ready", 32'(in_ready),  32'd1);
        step(1, 4'd6, 4'd3, 2'b11, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("t5_after", 32'(out_result), 32'h7);

`ifdef ALU_ZERO_FLAG_EN
        // 6: zero flag tracks the captured result
        step(1, 4'd5, 4'd5, 2'b01, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("t6_zero1", 32'(out_zero), 32'd1);
        step(1, 4'd1, 4'd0, 2'b11, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("t6_zero0", 32'(out_zero), 32'd0);
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7),
                 DATA_W'($urandom_range(0, 15)),
                 DATA_W'($urandom_range(0, 15)),
                 OP_W'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
